uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
UART receive side of the serial link. Recovers 11-bit frames from RxD: start bit, 8 data bits LSB first, even parity bit, stop bit. Bit timing uses 16x oversampling driven by sample_ENABLE from a Baud_controller instance sharing baud_select with the transmitter. Delivers each received byte with a one-cycle valid strobe, plus parity and framing error flags.

Parameters:
OVERSAMPLE, 16, sample_ENABLE ticks per bit period.
MID_TICK, 8, tick index within a bit at which the bit is sampled.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
baud_select  input  3  baud rate code, passed to Baud_controller
Rx_EN  input  1  receiver enable; 0 = receiver off
RxD  input  1  serial line, idle high, asynchronous to clk
Rx_DATA  output  8  last received byte
Rx_VALID  output  1  one-cycle pulse: new error-free byte on Rx_DATA
Rx_PERROR  output  1  parity error on last frame
Rx_FERROR  output  1  framing error (stop bit sampled 0) on last frame

Behaviour:
- Reset (synchronous, active-high): state OFF, Rx_DATA=8'h00, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, tick counter=0, bit index=0, synchronizer flops=1.
- RxD passes through a 2-flop synchronizer before any use. All references to RxD below mean the synchronized value.
- Tick counter is 4 bits. It advances only on sample_ENABLE and wraps from 15 to 0, which marks one bit period. It clears on entry to START.
- States:
  - OFF: if Rx_EN=1, go to IDLE.
  - IDLE: only entered from OFF or STOP. Start detection is armed only after RxD has been seen high. When armed and RxD=0, go to START and clear Rx_PERROR and Rx_FERROR.
  - START: at tick MID_TICK, if RxD=1 it is a false start: return to IDLE with no outputs changed. Otherwise stay in START and go to DATA when the bit period wraps.
  - DATA: samples at MID_TICK of each bit into a shift register, LSB first. After bit index 7, go to PARITY at the wrap.
  - PARITY: samples at MID_TICK. Expected bit is ^data (even parity, matching the transmitter).
  - STOP: samples at MID_TICK, then goes straight to IDLE. This half-bit early exit allows resynchronization.
- Completion, in the clk cycle after the STOP mid-sample:
  - Rx_DATA is loaded with the shift register in every case.
  - Rx_PERROR = (sampled parity != ^data).
  - Rx_FERROR = (stop bit == 0).
  - Rx_VALID pulses high for exactly 1 cycle only if both error flags are 0.
  - Error flags are sticky until the next accepted start bit, Rx_EN=0, or reset.
- Break or stuck-low line: after a framing error, IDLE does not re-arm until RxD returns to 1. A held-low line produces exactly one FERROR frame.
- Rx_EN=0 in any state: go to OFF on the next clk and abort any partial frame. No Rx_VALID is produced. Error flags clear. Rx_DATA keeps its value.
- Reset mid-frame: all state returns to reset values on the next clk.
- sample_ENABLE is a 1-cycle pulse at 16x the baud rate. Between pulses the FSM holds.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of samples taken at ticks MID_TICK-1, MID_TICK and MID_TICK+1. The false-start check uses the same vote, and the decision is taken at MID_TICK+1.
- Undefined: a single sample at MID_TICK. The two extra sample flops are not synthesized.

Decomposition:
- Shared package/header: state encodings (OFF, IDLE, START, DATA, PARITY, STOP), OVERSAMPLE and MID_TICK constants, and a frame-length constant. The transmitter uses the same header.
- One sub-module: the existing Baud_controller, instantiated to generate sample_ENABLE. The synchronizer and FSM stay in uart_receiver.

Test Plan:
- Frame 8'hA5, parity 0, stop 1, baud_select=3'b111 -> Rx_VALID pulses once, Rx_DATA=8'hA5, Rx_PERROR=0, Rx_FERROR=0.
- Frame 8'h01 with parity bit driven 0 (correct is 1) -> no Rx_VALID, Rx_DATA=8'h01, Rx_PERROR=1 until the next start bit.
- Frame 8'h3C with stop bit 0, then line held low for 3 frame times -> exactly one Rx_FERROR=1, no Rx_VALID; after RxD returns high, a frame 8'h55 gives Rx_VALID with 8'h55 and both flags clear.
- Glitch: RxD low for 4 sample ticks in IDLE -> FSM returns to IDLE, no outputs change; a following frame 8'hF0 is received correctly.
- Rx_EN dropped during data bit 3 of frame 8'hC3 -> OFF next clk, no Rx_VALID, Rx_DATA keeps its old value; re-enable and send 8'h7E -> received OK.
- Back-to-back: two frames 8'h12, 8'h34 with no idle gap, plus reset asserted mid-way through a third frame -> two Rx_VALID pulses with the correct bytes; after reset all outputs equal their reset values.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: FSM state encodings, bit-timing constants and the
// baud-select to sample_ENABLE divisor table. The transmitter uses the same package.
// The divisor table assumes a 7.3728 MHz system clock, which gives an exact
// 16x oversampling rate for every standard baud rate in the table.
package uart_receiver_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;  // sample_ENABLE ticks per bit period
    localparam int MID_TICK   = 8;   // tick within a bit where it is sampled
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop
    localparam int BAUD_CNT_W = 11;  // wide enough for the slowest divisor

    // Clock cycles per sample_ENABLE tick for each baud_select code.
    function automatic logic [BAUD_CNT_W-1:0] baud_divisor(input logic [2:0] sel);
        logic [BAUD_CNT_W-1:0] div;
        case (sel)
            3'd0:    div = 11'd1536;  // 300 baud
            3'd1:    div = 11'd384;   // 1200 baud
            3'd2:    div = 11'd96;    // 4800 baud
            3'd3:    div = 11'd48;    // 9600 baud
            3'd4:    div = 11'd24;    // 19200 baud
            3'd5:    div = 11'd12;    // 38400 baud
            3'd6:    div = 11'd8;     // 57600 baud
            default: div = 11'd4;     // 115200 baud
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_receiver_baud_controller.sv
// Baud controller: divides clk down to a one-cycle sample_ENABLE pulse at
// 16x the baud rate selected by baud_select.
module uart_receiver_baud_controller
    import uart_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [BAUD_CNT_W-1:0] count_q, count_d;
    logic [BAUD_CNT_W-1:0] limit;
    logic                  enable_q, enable_d;

    // Count up to divisor-1; the >= compare keeps the counter bounded when
    // baud_select is switched to a faster rate mid-count.
    always_comb begin
        limit    = baud_divisor(baud_select) - BAUD_CNT_W'(1);
        count_d  = count_q + BAUD_CNT_W'(1);
        enable_d = 1'b0;
        if (count_q >= limit) begin
            count_d  = '0;
            enable_d = 1'b1;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            enable_q <= enable_d;
        end
    end

    assign sample_ENABLE = enable_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronizer on RxD, 16x oversampled frame FSM
// (start, 8 data bits LSB first, even parity, stop), one-cycle Rx_VALID
// strobe and sticky parity/framing error flags.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit is the 2-of-3
// majority of samples at ticks MID_TICK-1, MID_TICK, MID_TICK+1, decided at
// MID_TICK+1. Without it a single sample at MID_TICK is used.
module uart_receiver
    import uart_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] EARLY_TICK  = 4'(MID_TICK - 1);
    localparam logic [3:0] CENTER_TICK = 4'(MID_TICK);
    localparam logic [3:0] DECIDE_TICK = 4'(MID_TICK + 1);
`else
    localparam logic [3:0] DECIDE_TICK = 4'(MID_TICK);
`endif

    logic                 sample_ENABLE;
    logic                 rxd_meta_q, rxd_sync_q;
    rx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perror_q, perror_d;
    logic                 ferror_q, ferror_d;
    logic                 bit_val;
    logic                 decide;
    logic                 wrap;

    uart_receiver_baud_controller u_baud (
        .clk           (clk),
        .reset         (reset),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_ENABLE)
    );

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic early_q, mid_q;

    // Hold the two samples that precede the decision tick for the 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else if (sample_ENABLE) begin
            if (tick_q == EARLY_TICK)  early_q <= rxd_sync_q;
            if (tick_q == CENTER_TICK) mid_q   <= rxd_sync_q;
        end
    end

    assign bit_val = (early_q & mid_q) | (early_q & rxd_sync_q) | (mid_q & rxd_sync_q);
`else
    assign bit_val = rxd_sync_q;
`endif

    assign decide = sample_ENABLE && (tick_q == DECIDE_TICK);
    assign wrap   = sample_ENABLE && (tick_q == LAST_TICK);

    // Next-state and output logic; everything except Rx_EN=0 advances only on sample ticks.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        armed_d   = armed_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perror_d  = perror_q;
        ferror_d  = ferror_q;

        if (sample_ENABLE) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            ST_OFF: begin
                tick_d    = '0;
                bit_idx_d = '0;
                armed_d   = 1'b0;
                if (sample_ENABLE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // A low line only counts as a start once it has been seen high,
                // so a broken/stuck-low line yields one framing error, not a stream.
                if (sample_ENABLE) begin
                    if (rxd_sync_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d   = ST_START;
                        tick_d    = '0;
                        bit_idx_d = '0;
                        perror_d  = 1'b0;
                        ferror_d  = 1'b0;
                    end
                end
            end
            ST_START: begin
                if (decide && bit_val) begin
                    state_d = ST_IDLE;       // false start; line already seen high
                end else if (wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                end
                if (wrap) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_PARITY;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    parity_d = bit_val;
                end
                if (wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so the next start edge is never missed.
                if (decide) begin
                    state_d  = ST_IDLE;
                    data_d   = shift_q;
                    perror_d = (parity_q != ^shift_q);
                    ferror_d = ~bit_val;
                    valid_d  = (parity_q == ^shift_q) && bit_val;
                    armed_d  = bit_val;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase

        if (!Rx_EN) begin
            state_d   = ST_OFF;
            tick_d    = '0;
            bit_idx_d = '0;
            armed_d   = 1'b0;
            valid_d   = 1'b0;
            perror_d  = 1'b0;
            ferror_d  = 1'b0;
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OFF;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perror_q  <= 1'b0;
            ferror_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perror_q  <= perror_d;
            ferror_q  <= ferror_d;
        end
    end

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perror_q;
    assign Rx_FERROR = ferror_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios followed by
// randomized frames, all checked against a frame-level reference model.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .Rx_EN       (Rx_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         bit_cyc = 64;
    int         valid_cnt = 0;
    int         ferr_rise = 0;
    logic [7:0] valid_bytes[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit period in clk cycles from the baud rate and a 7.3728 MHz clock.
    task automatic set_baud(input logic [2:0] sel);
        int rates[8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
        baud_select = sel;
        bit_cyc = 7372800 / rates[sel];
    endtask

    // Observe strobes and error-flag onsets on every cycle.
    always @(negedge clk) begin
        if (Rx_VALID) begin
            valid_cnt++;
            valid_bytes.push_back(Rx_DATA);
            check_eq("valid_width", {31'b0, prev_valid}, 32'd0);
        end
        if (Rx_FERROR && !prev_ferr) ferr_rise++;
        prev_valid = Rx_VALID;
        prev_ferr  = Rx_FERROR;
    end

    task automatic drive_bit(input logic b);
        @(negedge clk) RxD = b;
        repeat (bit_cyc - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stp);
    endtask

    // Reference: even parity means data+parity carry an even number of ones;
    // a zero stop bit is a framing error; only clean frames are strobed.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic par,
                                input logic stp, input int v_before);
        logic pe, fe;
        pe = ($countones({d, par}) % 2) != 0;
        fe = (stp == 1'b0);
        check_eq({tag, "_data"},   {24'b0, Rx_DATA}, {24'b0, d});
        check_eq({tag, "_perror"}, {31'b0, Rx_PERROR}, {31'b0, pe});
        check_eq({tag, "_ferror"}, {31'b0, Rx_FERROR}, {31'b0, fe});
        check_eq({tag, "_nvalid"}, valid_cnt - v_before, (pe || fe) ? 32'd0 : 32'd1);
        if (!pe && !fe) check_eq({tag, "_vbyte"}, {24'b0, valid_bytes[$]}, {24'b0, d});
    endtask

    task automatic expect_reset_outputs(input string tag);
        check_eq({tag, "_data"},   {24'b0, Rx_DATA}, 32'd0);
        check_eq({tag, "_valid"},  {31'b0, Rx_VALID}, 32'd0);
        check_eq({tag, "_perror"}, {31'b0, Rx_PERROR}, 32'd0);
        check_eq({tag, "_ferror"}, {31'b0, Rx_FERROR}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0;
        int         f0;
        logic [7:0] d;
        logic       par;
        logic       stp;

        reset = 1'b1;
        Rx_EN = 1'b0;
        RxD   = 1'b1;
        set_baud(3'd7);
        repeat (5) @(negedge clk);
        expect_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk) Rx_EN = 1'b1;
        idle_bits(2);

        // Clean frame.
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        expect_frame("a5", 8'hA5, 1'b0, 1'b1, v0);
        idle_bits(1);

        // Parity error, sticky while idle.
        v0 = valid_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        expect_frame("p01", 8'h01, 1'b0, 1'b1, v0);
        idle_bits(3);
        check_eq("perror_sticky", {31'b0, Rx_PERROR}, 32'd1);

        // Framing error followed by a long break.
        v0 = valid_cnt;
        f0 = ferr_rise;
        d  = 8'h3C;
        drive_bit(1'b0);
        drive_bit(d[0]);
        check_eq("perror_cleared_by_start", {31'b0, Rx_PERROR}, 32'd0);
        for (int i = 1; i < 8; i++) drive_bit(d[i]);
        drive_bit(^d);
        drive_bit(1'b0);
        expect_frame("f3c", d, ^d, 1'b0, v0);
        repeat (3 * 11 * bit_cyc) @(negedge clk);
        check_eq("break_ferror_held", {31'b0, Rx_FERROR}, 32'd1);
        check_eq("break_one_ferror", ferr_rise - f0, 32'd1);
        check_eq("break_no_valid", valid_cnt - v0, 32'd0);
        idle_bits(2);
        v0 = valid_cnt;
        send_frame(8'h55, ^8'h55, 1'b1);
        expect_frame("r55", 8'h55, ^8'h55, 1'b1, v0);
        idle_bits(1);

        // Short glitch in IDLE is rejected.
        v0 = valid_cnt;
        @(negedge clk) RxD = 1'b0;
        repeat (4 * (bit_cyc / 16) - 1) @(negedge clk);
        @(negedge clk) RxD = 1'b1;
        idle_bits(2);
        check_eq("glitch_nvalid", valid_cnt - v0, 32'd0);
        check_eq("glitch_data", {24'b0, Rx_DATA}, 32'h55);
        check_eq("glitch_perror", {31'b0, Rx_PERROR}, 32'd0);
        check_eq("glitch_ferror", {31'b0, Rx_FERROR}, 32'd0);
        v0 = valid_cnt;
        send_frame(8'hF0, ^8'hF0, 1'b1);
        expect_frame("f0", 8'hF0, ^8'hF0, 1'b1, v0);
        idle_bits(1);

        // Disabling clears error flags but keeps the last byte.
        v0 = valid_cnt;
        send_frame(8'h80, 1'b0, 1'b1);
        expect_frame("p80", 8'h80, 1'b0, 1'b1, v0);
        @(negedge clk) Rx_EN = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("dis_perror", {31'b0, Rx_PERROR}, 32'd0);
        check_eq("dis_data", {24'b0, Rx_DATA}, 32'h80);
        Rx_EN = 1'b1;
        idle_bits(2);

        // Abort during data bit 3.
        v0 = valid_cnt;
        d  = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        @(negedge clk) RxD = d[3];
        repeat (bit_cyc / 2) @(negedge clk);
        Rx_EN = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_data", {24'b0, Rx_DATA}, 32'h80);
        for (int i = 4; i < 8; i++) drive_bit(d[i]);
        drive_bit(^d);
        drive_bit(1'b1);
        check_eq("abort_nvalid", valid_cnt - v0, 32'd0);
        check_eq("abort_data_end", {24'b0, Rx_DATA}, 32'h80);
        @(negedge clk) Rx_EN = 1'b1;
        idle_bits(2);
        v0 = valid_cnt;
        send_frame(8'h7E, ^8'h7E, 1'b1);
        expect_frame("r7e", 8'h7E, ^8'h7E, 1'b1, v0);
        idle_bits(1);

        // Back-to-back frames, then reset during a third.
        v0 = valid_cnt;
        send_frame(8'h12, ^8'h12, 1'b1);
        send_frame(8'h34, ^8'h34, 1'b1);
        expect_frame("b34", 8'h34, ^8'h34, 1'b1, v0 + 1);
        check_eq("b2b_nvalid", valid_cnt - v0, 32'd2);
        check_eq("b2b_first", {24'b0, valid_bytes[valid_bytes.size() - 2]}, 32'h12);
        d = 8'h9A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        @(negedge clk);
        reset = 1'b1;
        RxD   = 1'b1;
        repeat (2) @(negedge clk);
        expect_reset_outputs("midreset");
        reset = 1'b0;
        idle_bits(2);

        // Randomized frames across two baud rates with injected errors.
        for (int k = 0; k < 20; k++) begin
            set_baud(3'($urandom_range(6, 7)));
            idle_bits(2);
            d   = 8'($urandom);
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            stp = ($urandom_range(0, 7) != 0);
            v0  = valid_cnt;
            send_frame(d, par, stp);
            expect_frame($sformatf("rnd%0d", k), d, par, stp, v0);
            idle_bits($urandom_range(1, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
